rgb_memory_top: RTL and testbench
=================================

// Module: rgb_memory_top
// PURPOSE
//  3-bit RGB framebuffer between the VGA timing generator and the DAC pins.
//  Stores a coarse image of 40x30 cells, each cell 32x32 screen pixels, packed two cells per memory word.
//  While display_on=0 it writes RGBin at the cell under (hpos,vpos).
//  While display_on=1 it reads the cell under (hpos,vpos) and drives RGB.
//  A memreset phase clears the memory word-by-word, addressed externally by resetcnt.
// PARAMETERS
//  DATA_WIDTH    6     memory word width = 2 cells x 3 bits (lane0=[2:0], lane1=[5:3])
//  ADDR_WIDTH    10    word address width; 1024 words, 600 used
//  RESOLUTION_H  1280  visible pixels per line
//  RESOLUTION_V  960   visible lines
//  H_FRONT/H_SYNC/H_BACK    80/136/216  horizontal porches and sync (used only to size X_WIRE_WIDTH)
//  V_BOTTOM/V_SYNC/V_TOP    1/3/30      vertical porches and sync (used only to size Y_WIRE_WIDTH)
//  X_WIRE_WIDTH  $clog2(RESOLUTION_H+H_FRONT+H_SYNC+H_BACK) = 11
//  Y_WIRE_WIDTH  $clog2(RESOLUTION_V+V_BOTTOM+V_SYNC+V_TOP) = 10
// PORTS
//  clk         in   1             single system/pixel clock, rising edge
//  reset_n     in   1             asynchronous reset, active low
//  memreset    in   1             0 = clear phase; 1 = normal operation
//  resetcnt    in   ADDR_WIDTH    word address cleared during the clear phase
//  display_on  in   1             1 = read/display; 0 = write
//  hpos        in   X_WIRE_WIDTH  pixel column
//  vpos        in   Y_WIRE_WIDTH  pixel line
//  RGBin       in   3             colour to write
//  RGB         out  3             displayed colour, registered
// BEHAVIOUR
//  - Reset: reset_n=0 asynchronously sets RGB to 3'b000. Memory contents are not reset.
//  - Addressing: col=hpos>>5 (0..39); row=vpos>>5 (0..29).
//    word = row*20 + (col>>1) (0..599); lane = col[0].
//  - in_range = (hpos<RESOLUTION_H) && (vpos<RESOLUTION_V).
//  - Clear (memreset=0): each rising edge writes 6'b0 to word resetcnt when resetcnt<1024.
//    No pixel writes occur. RGB is registered to 0.
//  - Write (memreset=1, display_on=0, in_range): at the rising edge, the selected lane of the word takes RGBin.
//    The other lane is preserved, using per-lane write enables; no read-modify-write.
//    RGB is registered to 0 (blanking).
//  - Read (memreset=1, display_on=1): synchronous read.
//    RGB is valid after the first rising edge following a stable (hpos,vpos), i.e. 1-cycle latency.
//    Lane select is pipelined with the address. Out of range -> RGB=0.
//  - Writes with !in_range are ignored.
//  - Back-to-back writes: one per cycle, all take effect.
//  - A read in the cycle after a write to the same cell returns the new value.
//  - A rewrite of the same cell: last value wins.
//  - reset_n asserted mid-operation: clears the RGB register only. Memory and the clear sequence are unaffected.
// TESTING
//  1. reset_n=0 for 2 cycles -> RGB=0.
//     Then memreset=0 with resetcnt=0..799, one per cycle; memreset=1, display_on=1, hpos=0, vpos=0 -> RGB=0.
//  2. display_on=0; write (600,500)=3'b011, (400,200)=3'b101, (700,800)=3'b110.
//     display_on=1; read each for one cycle -> RGB 011, 101, 110 respectively; (0,0) -> 000.
//  3. Lane isolation: write (0,0)=3'b111 and (32,0)=3'b010 (same word).
//     Read back -> 111 and 010; (64,0) -> 000.
//  4. Ten random in-range pixels in distinct cells with random colours, each written for 5 cycles.
//     Read each back with 1-cycle latency -> exact match. Any mismatch is reported with hpos, vpos and the expected colour.
//  5. Out of range: write at hpos=1300 -> no cell changes; read at hpos=1300 -> RGB=0.
//     display_on=0 -> RGB=0.
//  6. Assert reset_n mid-display -> RGB=0 immediately. After release, reads return the previously written data.

Source files
------------

// File: rtl/rgb_memory_top.sv
// 3-bit RGB framebuffer: 40x30 cells of 32x32 pixels, two cells packed per memory word.
// Pixel writes happen while blanked, registered reads while displaying, and an external word-by-word clear.
module rgb_memory_top #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 10,
  parameter int RESOLUTION_H = 1280,
  parameter int RESOLUTION_V = 960,
  parameter int H_FRONT      = 80,
  parameter int H_SYNC       = 136,
  parameter int H_BACK       = 216,
  parameter int V_BOTTOM     = 1,
  parameter int V_SYNC       = 3,
  parameter int V_TOP        = 30,
  parameter int X_WIRE_WIDTH = $clog2(RESOLUTION_H + H_FRONT + H_SYNC + H_BACK),
  parameter int Y_WIRE_WIDTH = $clog2(RESOLUTION_V + V_BOTTOM + V_SYNC + V_TOP)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    memreset,
  input  logic [ADDR_WIDTH-1:0]   resetcnt,
  input  logic                    display_on,
  input  logic [X_WIRE_WIDTH-1:0] hpos,
  input  logic [Y_WIRE_WIDTH-1:0] vpos,
  input  logic [2:0]              RGBin,
  output logic [2:0]              RGB
);

  localparam int LANES         = 2;
  localparam int PIX_W         = DATA_WIDTH / LANES;
  localparam int CELL_SHIFT    = 5;
  localparam int COL_W         = X_WIRE_WIDTH - CELL_SHIFT;
  localparam int ROW_W         = Y_WIRE_WIDTH - CELL_SHIFT;
  localparam int WORDS_PER_ROW = (RESOLUTION_H >> CELL_SHIFT) / LANES;
  localparam int DEPTH         = 1 << ADDR_WIDTH;

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic                  lane;
  logic                  in_range;
  logic                  clear_phase;
  logic                  pix_wr;
  logic [ADDR_WIDTH-1:0] pix_word;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  valid_d;
  logic                  valid_q;
  logic                  lane_q;

  assign col      = hpos[X_WIRE_WIDTH-1:CELL_SHIFT];
  assign row      = vpos[Y_WIRE_WIDTH-1:CELL_SHIFT];
  assign lane     = col[0];
  assign pix_word = ADDR_WIDTH'(row) * ADDR_WIDTH'(WORDS_PER_ROW)
                  + ADDR_WIDTH'(col[COL_W-1:1]);
  assign in_range = (hpos < X_WIRE_WIDTH'(RESOLUTION_H)) &&
                    (vpos < Y_WIRE_WIDTH'(RESOLUTION_V));

  assign clear_phase = !memreset;
  assign pix_wr      = memreset && !display_on && in_range;
  assign valid_d     = memreset && display_on && in_range;

  // Pixel reads and writes never overlap, so a single address port serves both lanes.
  assign ram_addr = clear_phase ? resetcnt : pix_word;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [PIX_W-1:0] mem [DEPTH];
      logic [PIX_W-1:0] rd_q;
      logic             we;
      logic [PIX_W-1:0] wdata;

      // Per-lane enable keeps the neighbouring cell intact without a read-modify-write.
      assign we    = clear_phase || (pix_wr && (lane == 1'(gi)));
      assign wdata = clear_phase ? '0 : RGBin;

      always_ff @(posedge clk) begin
        if (we) begin
          mem[ram_addr] <= wdata;
        end
        rd_q <= mem[ram_addr];
      end

      assign rd_data[gi*PIX_W +: PIX_W] = rd_q;
    end
  endgenerate

  // Lane select and the display qualifier travel alongside the RAM read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      lane_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      lane_q  <= lane;
    end
  end

  always_comb begin
    RGB = '0;
    if (valid_q) begin
      RGB = lane_q ? rd_data[2*PIX_W-1:PIX_W] : rd_data[PIX_W-1:0];
    end
  end

endmodule

// File: tb/tb_rgb_memory_top.sv
// Directed bench for rgb_memory_top: clear, write/read, lane isolation, range limits,
// back-to-back traffic and asynchronous reset of the output.
module tb_rgb_memory_top;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memreset;
  logic [9:0]  resetcnt;
  logic        display_on;
  logic [10:0] hpos;
  logic [9:0]  vpos;
  logic [2:0]  RGBin;
  logic [2:0]  RGB;

  int errors = 0;
  int checks = 0;

  // Ten distinct cells (col,row noted) with hand-picked colours.
  int         th [10] = '{100, 1000, 1279, 33, 640, 672, 250, 900, 150, 1200};
  int         tv [10] = '{40,  70,   959,  900, 480, 480, 300, 600, 930, 10};
  logic [2:0] tc [10] = '{3'b001, 3'b010, 3'b111, 3'b100, 3'b110,
                          3'b101, 3'b011, 3'b001, 3'b010, 3'b100};

  always #5 clk = ~clk;

  rgb_memory_top dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .memreset   (memreset),
    .resetcnt   (resetcnt),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
    .RGBin      (RGBin),
    .RGB        (RGB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pix(input int h, input int v, input logic [2:0] c, input int n);
    display_on = 1'b0;
    hpos       = 11'(h);
    vpos       = 10'(v);
    RGBin      = c;
    repeat (n) tick();
    $display("wr h=%0d v=%0d rgb=%b cycles=%0d", h, v, c, n);
  endtask

  task automatic read_pix(input int h, input int v, output logic [2:0] c);
    display_on = 1'b1;
    hpos       = 11'(h);
    vpos       = 10'(v);
    tick();
    c = RGB;
    $display("rd h=%0d v=%0d rgb=%b", h, v, c);
  endtask

  task automatic test_reset();
    logic [2:0] c;
    reset_n    = 1'b0;
    memreset   = 1'b1;
    display_on = 1'b1;
    repeat (2) tick();
    checks++;
    if (RGB !== 3'b000) begin
      errors++;
      $display("FAIL reset_rgb got=%b want=000", RGB);
    end
    reset_n  = 1'b1;
    memreset = 1'b0;
    for (int i = 0; i < 800; i++) begin
      resetcnt = 10'(i);
      tick();
    end
    checks++;
    if (RGB !== 3'b000) begin
      errors++;
      $display("FAIL clear_rgb got=%b want=000", RGB);
    end
    memreset = 1'b1;
    read_pix(0, 0, c);
    checks++;
    if (c !== 3'b000) begin
      errors++;
      $display("FAIL cleared_0_0 got=%b want=000", c);
    end
    read_pix(600, 500, c);
    checks++;
    if (c !== 3'b000) begin
      errors++;
      $display("FAIL cleared_600_500 got=%b want=000", c);
    end
    read_pix(1279, 959, c);
    checks++;
    if (c !== 3'b000) begin
      errors++;
      $display("FAIL cleared_1279_959 got=%b want=000", c);
    end
  endtask

  task automatic test_write_read();
    logic [2:0] c;
    write_pix(600, 500, 3'b011, 1);
    checks++;
    if (RGB !== 3'b000) begin
      errors++;
      $display("FAIL write_blanking got=%b want=000", RGB);
    end
    write_pix(400, 200, 3'b101, 1);
    write_pix(700, 800, 3'b110, 1);
    read_pix(600, 500, c);
    checks++;
    if (c !== 3'b011) begin
      errors++;
      $display("FAIL rd_600_500 got=%b want=011", c);
    end
    read_pix(400, 200, c);
    checks++;
    if (c !== 3'b101) begin
      errors++;
      $display("FAIL rd_400_200 got=%b want=101", c);
    end
    read_pix(700, 800, c);
    checks++;
    if (c !== 3'b110) begin
      errors++;
      $display("FAIL rd_700_800 got=%b want=110", c);
    end
    read_pix(0, 0, c);
    checks++;
    if (c !== 3'b000) begin
      errors++;
      $display("FAIL rd_0_0 got=%b want=000", c);
    end
  endtask

  task automatic test_lane_isolation();
    logic [2:0] c;
    write_pix(0, 0, 3'b111, 1);
    write_pix(32, 0, 3'b010, 1);
    read_pix(0, 0, c);
    checks++;
    if (c !== 3'b111) begin
      errors++;
      $display("FAIL lane0 got=%b want=111", c);
    end
    read_pix(32, 0, c);
    checks++;
    if (c !== 3'b010) begin
      errors++;
      $display("FAIL lane1 got=%b want=010", c);
    end
    read_pix(64, 0, c);
    checks++;
    if (c !== 3'b000) begin
      errors++;
      $display("FAIL lane_next_word got=%b want=000", c);
    end
  endtask

  task automatic test_cells();
    logic [2:0] c;
    for (int i = 0; i < 10; i++) write_pix(th[i], tv[i], tc[i], 5);
    for (int i = 0; i < 10; i++) begin
      read_pix(th[i], tv[i], c);
      checks++;
      if (c !== tc[i]) begin
        errors++;
        $display("FAIL cell hpos=%0d vpos=%0d got=%b want=%b", th[i], tv[i], c, tc[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] c;
    // hpos=1300 would alias to (0,512) if the range gate were missing.
    write_pix(1300, 500, 3'b111, 2);
    read_pix(0, 512, c);
    checks++;
    if (c !== 3'b000) begin
      errors++;
      $display("FAIL oor_alias got=%b want=000", c);
    end
    read_pix(1279, 500, c);
    checks++;
    if (c !== 3'b000) begin
      errors++;
      $display("FAIL oor_row_end got=%b want=000", c);
    end
    read_pix(1300, 500, c);
    checks++;
    if (c !== 3'b000) begin
      errors++;
      $display("FAIL oor_read got=%b want=000", c);
    end
    read_pix(600, 500, c);
    checks++;
    if (c !== 3'b011) begin
      errors++;
      $display("FAIL oor_prior got=%b want=011", c);
    end
    display_on = 1'b0;
    hpos       = 11'd1300;
    tick();
    checks++;
    if (RGB !== 3'b000) begin
      errors++;
      $display("FAIL display_off got=%b want=000", RGB);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] c;
    write_pix(768, 100, 3'b001, 1);
    write_pix(800, 100, 3'b110, 1);
    write_pix(832, 100, 3'b011, 1);
    read_pix(832, 100, c);
    checks++;
    if (c !== 3'b011) begin
      errors++;
      $display("FAIL raw_same_cell got=%b want=011", c);
    end
    read_pix(768, 100, c);
    checks++;
    if (c !== 3'b001) begin
      errors++;
      $display("FAIL b2b_768 got=%b want=001", c);
    end
    read_pix(800, 100, c);
    checks++;
    if (c !== 3'b110) begin
      errors++;
      $display("FAIL b2b_800 got=%b want=110", c);
    end
    write_pix(768, 100, 3'b111, 1);
    write_pix(768, 100, 3'b010, 1);
    read_pix(768, 100, c);
    checks++;
    if (c !== 3'b010) begin
      errors++;
      $display("FAIL rewrite got=%b want=010", c);
    end
    read_pix(800, 100, c);
    checks++;
    if (c !== 3'b110) begin
      errors++;
      $display("FAIL rewrite_neighbour got=%b want=110", c);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] c;
    read_pix(400, 200, c);
    checks++;
    if (c !== 3'b101) begin
      errors++;
      $display("FAIL pre_reset got=%b want=101", c);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (RGB !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got=%b want=000", RGB);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    read_pix(400, 200, c);
    checks++;
    if (c !== 3'b101) begin
      errors++;
      $display("FAIL post_reset_400_200 got=%b want=101", c);
    end
    read_pix(1279, 959, c);
    checks++;
    if (c !== 3'b111) begin
      errors++;
      $display("FAIL post_reset_1279_959 got=%b want=111", c);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    memreset   = 1'b1;
    resetcnt   = '0;
    display_on = 1'b1;
    hpos       = '0;
    vpos       = '0;
    RGBin      = '0;
    test_reset();
    test_write_read();
    test_lane_isolation();
    test_cells();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
